// File: rtl/alu_result_pipe_pkg.sv
// Shared datapath package for the multicycle core.
// Holds the default datapath geometry and the helper that sizes occupancy counters.
package alu_result_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to count 0..depth valid entries inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/alu_result_pipe_if.sv
// Handshake bundle between the ALU result producer, the result pipe and its consumer.
// master = the surrounding logic (upstream and downstream); slave = the pipe itself.
interface alu_result_pipe_if
    import alu_result_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         in_ready;
    logic                         flush;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [occ_width(DEPTH)-1:0]  occupancy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/alu_result_pipe_stage.sv
// One pipe stage: a valid bit plus a data register.
// The stage only stores; deciding when to load or clear belongs to the parent.
module pipe_stage
    import alu_result_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid/data update: reset wins, then clear (valid only), then load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every stage samples pre-edge values of its neighbours.
        if (reset) begin
            r_valid <= 1'b0;
            // NOTE: data is reset here on purpose so out_data shows a known value after reset;
            // clear leaves data untouched so the output holds its last value.
            r_data  <= RESET_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_result_pipe.sv
// Elastic register pipe for ALU results with bubble collapsing, flush and occupancy count.
// Stage 0 faces the producer; stage DEPTH-1 drives out_valid/out_data.
module alu_result_pipe
    import alu_result_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_pipe_if.slave  bus
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data     [DEPTH];
    logic [WIDTH-1:0] w_stage_in [DEPTH];
    logic [DEPTH-1:0] w_take;    // stage k can accept a new entry this cycle
    logic [DEPTH-1:0] w_adv;     // stage k hands its entry on (or out) this cycle
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_in_ready;
    logic [OCC_W-1:0] r_occupancy;

    // Output valid is masked while reset is high so nothing is offered or consumed during reset.
    assign bus.out_valid = w_valid[DEPTH-1] & ~reset;
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.in_ready  = w_in_ready;
    assign bus.occupancy = r_occupancy;

    assign w_out_fire = bus.out_valid & bus.out_ready;
    assign w_in_fire  = bus.in_valid & w_in_ready;

    // Ready/advance chain from the output backwards, then per-stage load/clear controls.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        w_take     = '0;
        w_adv      = '0;
        w_load     = '0;
        w_clear    = '0;
        w_in_ready = 1'b0;

        w_adv[DEPTH-1] = w_out_fire;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            w_take[k]  = ~w_valid[k] | w_adv[k];
            w_adv[k-1] = w_valid[k-1] & w_take[k];
        end
        w_take[0] = ~w_valid[0] | w_adv[0];

        w_in_ready = ~reset & ~bus.flush & w_take[0];

        w_load[0] = w_in_fire;
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1] & ~bus.flush;
        end

        for (int k = 0; k < DEPTH; k++) begin
            w_clear[k] = bus.flush | (w_adv[k] & ~w_load[k]);
        end
    end

    // Stage 0 takes the producer's data; every other stage takes its predecessor's.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_stage_in[k] = bus.in_data;
        end else begin : g_rest
            assign w_stage_in[k] = w_data[k-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[k]),
            .i_clear (w_clear[k]),
            .i_data  (w_stage_in[k]),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k])
        );
    end

    // Occupancy counter tracks in/out transfers; flush and reset zero it.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_occupancy <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

endmodule
